regalu_seq_ctrl: RTL and testbench

Single-clock sequencer for the register-file / operand-latch / ALU / result-latch datapath. It accepts ALU commands through a valid/ready queue and drives each one through the read (RR), execute (F latch) and write-back (WB) phases. It generates the register addresses, the ALU opcode, the write strobe and one-cycle phase enables, which replace the separate phase clocks. It also captures the ALU flags and counts retired commands.

---
 rtl/regalu_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_regalu_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regalu_seq_ctrl.sv
// Sequencer for the register-file / operand-latch / ALU / result-latch datapath.
// Commands queue in a small FIFO and are walked through RR, EX and WB with one-cycle phase enables.
//
// state | meaning
// IDLE  | waiting for a queued command
// RR    | operand latches load (rr_en)
// EX    | result latch loads (f_en), ALU flags captured
// WB    | register-file write (Reg_Write), command retires (done)
module regalu_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_rs1,
  input  logic [4:0]       cmd_rs2,
  input  logic [4:0]       cmd_rd,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_we,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       R_Addr_B,
  output logic [4:0]       W_Addr,
  output logic [3:0]       ALU_OP,
  output logic             Reg_Write,
  output logic             rr_en,
  output logic             f_en,
  output logic             wb_en,
  input  logic [3:0]       flags_in,
  output logic [3:0]       flags_out,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RR, EX, WB} state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] op;
    logic       we;
  } cmd_t;

  state_t          state, state_nxt;
  cmd_t            fifo_mem [DEPTH];
  cmd_t            cmd_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;

  // Ready is derived from the registered count only, so a same-cycle pop never frees a slot early.
  assign cmd_ready = !rst && (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) || (count != '0);

  assign R_Addr_A = cmd_q.rs1;
  assign R_Addr_B = cmd_q.rs2;
  assign W_Addr   = cmd_q.rd;
  assign ALU_OP   = cmd_q.op;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{cmd_rs1, cmd_rs2, cmd_rd, cmd_op, cmd_we};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      flags_out <= '0;
      op_count  <= '0;
    end else begin
      state <= state_nxt;
      if (pop)          cmd_q     <= fifo_mem[rd_ptr];
      if (state == EX)  flags_out <= flags_in;
      if (state == WB)  op_count  <= op_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rr_en     = 1'b0;
    f_en      = 1'b0;
    wb_en     = 1'b0;
    done      = 1'b0;
    Reg_Write = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = RR;
        end
      end
      RR: begin
        rr_en     = 1'b1;
        state_nxt = EX;
      end
      EX: begin
        f_en      = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        wb_en     = 1'b1;
        done      = 1'b1;
        // x0 is hardwired to zero, so writes to it are dropped here
        Reg_Write = cmd_q.we && (cmd_q.rd != 5'd0);
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = RR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regalu_seq_ctrl.sv
// Directed bench for regalu_seq_ctrl; a second instance with a 2-bit counter exercises op_count wrap.
module tb_regalu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic [3:0]  cmd_op = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  flags_in = '0;

  logic        cmd_ready, Reg_Write, rr_en, f_en, wb_en, done, busy;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [3:0]  ALU_OP, flags_out;
  logic [15:0] op_count;

  logic        cmd_ready_w, Reg_Write_w, rr_en_w, f_en_w, wb_en_w, done_w, busy_w;
  logic [4:0]  R_Addr_A_w, R_Addr_B_w, W_Addr_w;
  logic [3:0]  ALU_OP_w, flags_out_w;
  logic [1:0]  op_count_w;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regalu_seq_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_op(cmd_op), .cmd_we(cmd_we),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .ALU_OP(ALU_OP),
    .Reg_Write(Reg_Write), .rr_en(rr_en), .f_en(f_en), .wb_en(wb_en),
    .flags_in(flags_in), .flags_out(flags_out), .done(done), .busy(busy), .op_count(op_count)
  );

  regalu_seq_ctrl #(.DEPTH(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_op(cmd_op), .cmd_we(cmd_we),
    .R_Addr_A(R_Addr_A_w), .R_Addr_B(R_Addr_B_w), .W_Addr(W_Addr_w), .ALU_OP(ALU_OP_w),
    .Reg_Write(Reg_Write_w), .rr_en(rr_en_w), .f_en(f_en_w), .wb_en(wb_en_w),
    .flags_in(flags_in), .flags_out(flags_out_w), .done(done_w), .busy(busy_w), .op_count(op_count_w)
  );

  wire [45:0] all_out   = {cmd_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write, rr_en,
                           f_en, wb_en, flags_out, done, busy, op_count};
  wire [31:0] all_out_w = {cmd_ready_w, R_Addr_A_w, R_Addr_B_w, W_Addr_w, ALU_OP_w, Reg_Write_w,
                           rr_en_w, f_en_w, wb_en_w, flags_out_w, done_w, busy_w, op_count_w};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [3:0] op, input logic we);
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_rd    = rd;
    cmd_op    = op;
    cmd_we    = we;
    cmd_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    tick; tick;
    checks++; if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out); else passes++;
    checks++; if (all_out_w !== '0) $display("FAIL reset_outputs_w: got %h expected 0", all_out_w); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); else passes++;
    tick;
  endtask

  task automatic test_single;
    set_cmd(5'd1, 5'd2, 5'd3, 4'h0, 1'b1);
    tick; cmd_valid = 1'b0;
    checks++; if ({rr_en, busy} !== 2'b01) $display("FAIL single_c1: got rr_en,busy=%b expected 01", {rr_en, busy}); else passes++;
    tick;
    checks++; if ({rr_en, R_Addr_A, R_Addr_B} !== {1'b1, 5'd1, 5'd2})
      $display("FAIL single_rr: got %b/%0d/%0d expected 1/1/2", rr_en, R_Addr_A, R_Addr_B); else passes++;
    tick;
    checks++; if ({rr_en, f_en} !== 2'b01) $display("FAIL single_ex: got rr_en,f_en=%b expected 01", {rr_en, f_en}); else passes++;
    tick;
    checks++; if ({Reg_Write, wb_en, done, W_Addr, ALU_OP} !== {3'b111, 5'd3, 4'h0})
      $display("FAIL single_wb: got we,wb,done=%b W_Addr=%0d op=%0h expected 111/3/0", {Reg_Write, wb_en, done}, W_Addr, ALU_OP); else passes++;
    tick;
    checks++; if ({op_count, busy, done, R_Addr_A} !== {16'd1, 1'b0, 1'b0, 5'd1})
      $display("FAIL single_after: got cnt=%0d busy=%b done=%b A=%0d expected 1/0/0/1", op_count, busy, done, R_Addr_A); else passes++;
  endtask

  task automatic test_back_to_back;
    int base, n, rdy6;
    int pcyc [7];
    int dcyc [8];
    int dw [8];
    int dop [8];
    int exp_p [7] = '{0, 1, 2, 3, 4, 5, 8};
    base = cyc;
    n = 0;
    rdy6 = -1;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          int w;
          set_cmd(5'(i + 1), 5'(i + 2), 5'(i + 8), 4'(i), 1'b1);
          w = 0;
          while (!cmd_ready && w < 20) begin tick; w++; end
          pcyc[i] = cyc - base;
          tick;
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 30; t++) begin
          if (t == 6) rdy6 = int'(cmd_ready);
          if (done && n < 8) begin
            dcyc[n] = cyc - base;
            dw[n]   = int'(W_Addr);
            dop[n]  = int'(ALU_OP);
            n++;
          end
          tick;
        end
      end
    join
    checks++; if (rdy6 != 0) $display("FAIL b2b_full_ready: got %0d expected 0", rdy6); else passes++;
    for (int i = 0; i < 7; i++) begin
      checks++; if (pcyc[i] != exp_p[i]) $display("FAIL b2b_push_%0d: got cycle %0d expected %0d", i, pcyc[i], exp_p[i]); else passes++;
    end
    checks++; if (n != 7) $display("FAIL b2b_done_count: got %0d expected 7", n); else passes++;
    for (int k = 0; k < 7; k++) begin
      if (k < n) begin
        checks++; if (dcyc[k] != 4 + 3 * k || dw[k] != k + 8 || dop[k] != k)
          $display("FAIL b2b_done_%0d: got cyc=%0d wa=%0d op=%0d expected %0d/%0d/%0d", k, dcyc[k], dw[k], dop[k], 4 + 3 * k, k + 8, k);
        else passes++;
      end
    end
    checks++; if ({busy, op_count} !== {1'b0, 16'd8}) $display("FAIL b2b_end: got busy=%b cnt=%0d expected 0/8", busy, op_count); else passes++;
  endtask

  task automatic test_x0;
    logic saw_w;
    int dt;
    saw_w = 1'b0;
    dt = -1;
    set_cmd(5'd4, 5'd5, 5'd0, 4'h2, 1'b1);
    tick; cmd_valid = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      if (Reg_Write) saw_w = 1'b1;
      if (done) dt = t;
      tick;
    end
    checks++; if (saw_w !== 1'b0) $display("FAIL x0_no_write: got %b expected 0", saw_w); else passes++;
    checks++; if (dt != 4) $display("FAIL x0_done: got cycle %0d expected 4", dt); else passes++;
    checks++; if (op_count !== 16'd9) $display("FAIL x0_count: got %0d expected 9", op_count); else passes++;
  endtask

  task automatic test_flags;
    logic saw_w;
    saw_w = 1'b0;
    flags_in = 4'b0101;
    set_cmd(5'd6, 5'd7, 5'd9, 4'h3, 1'b0);
    tick; cmd_valid = 1'b0;
    saw_w |= Reg_Write;
    tick;
    saw_w |= Reg_Write;
    tick;
    flags_in = 4'b1010;
    saw_w |= Reg_Write;
    checks++; if ({f_en, flags_out} !== {1'b1, 4'b0000}) $display("FAIL flags_ex: got f_en=%b flags=%b expected 1/0000", f_en, flags_out); else passes++;
    tick;
    flags_in = 4'b0101;
    saw_w |= Reg_Write;
    checks++; if ({done, flags_out} !== {1'b1, 4'b1010}) $display("FAIL flags_wb: got done=%b flags=%b expected 1/1010", done, flags_out); else passes++;
    tick;
    saw_w |= Reg_Write;
    checks++; if (flags_out !== 4'b1010) $display("FAIL flags_hold: got %b expected 1010", flags_out); else passes++;
    checks++; if (saw_w !== 1'b0) $display("FAIL flags_no_write: got %b expected 0", saw_w); else passes++;
    checks++; if (op_count !== 16'd10) $display("FAIL flags_count: got %0d expected 10", op_count); else passes++;
    flags_in = 4'b0000;
  endtask

  task automatic test_wrap;
    checks++; if (op_count_w !== 2'd2) $display("FAIL wrap_start: got %0d expected 2", op_count_w); else passes++;
    set_cmd(5'd10, 5'd11, 5'd12, 4'h5, 1'b1);
    tick; cmd_valid = 1'b0;
    repeat (4) tick;
    checks++; if (op_count_w !== 2'd3) $display("FAIL wrap_pre: got %0d expected 3", op_count_w); else passes++;
    set_cmd(5'd13, 5'd14, 5'd15, 4'h6, 1'b1);
    tick; cmd_valid = 1'b0;
    repeat (4) tick;
    checks++; if ({op_count_w, op_count} !== {2'd0, 16'd12})
      $display("FAIL wrap_zero: got narrow=%0d wide=%0d expected 0/12", op_count_w, op_count); else passes++;
  endtask

  task automatic test_reset_mid;
    logic saw;
    saw = 1'b0;
    set_cmd(5'd1, 5'd1, 5'd5, 4'h1, 1'b1);
    tick;
    set_cmd(5'd2, 5'd2, 5'd6, 4'h2, 1'b1);
    tick;
    set_cmd(5'd3, 5'd3, 5'd7, 4'h3, 1'b1);
    tick; cmd_valid = 1'b0;
    checks++; if (f_en !== 1'b1) $display("FAIL rstmid_in_ex: got f_en=%b expected 1", f_en); else passes++;
    flags_in = 4'b1111;
    rst = 1'b1;
    tick;
    checks++; if (all_out !== '0) $display("FAIL rstmid_outputs: got %h expected 0", all_out); else passes++;
    tick;
    rst = 1'b0;
    flags_in = 4'b0000;
    #1;
    checks++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL rstmid_ready: got ready,busy=%b expected 10", {cmd_ready, busy}); else passes++;
    for (int t = 0; t < 10; t++) begin
      if (Reg_Write || done || busy) saw = 1'b1;
      tick;
    end
    checks++; if (saw !== 1'b0) $display("FAIL rstmid_quiet: got activity=%b expected 0", saw); else passes++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_x0;
    test_flags;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
